pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Parameter MAX_WAIT, default 15, range 1..255: fetch wait cycles before timeout.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_ready  input  1  instruction memory holds a valid instruction for the current pc.
REQ-006 stall  input  1  hazard stall; holds the sequencer in EXEC.
REQ-007 branch  input  1  branch control from the controller.
REQ-008 zero  input  1  ALU zero flag.
REQ-009 branch_target  input  32  shifted-adder branch target.
REQ-010 pc  output  32  current program counter (registered).
REQ-011 fetch_req  output  1  request to instruction memory; high only in FETCH.
REQ-012 instr_valid  output  1  one-cycle pulse on the FETCH->EXEC transition.
REQ-013 flush  output  1  one-cycle pulse when a taken branch updates pc.
REQ-014 fetch_timeout  output  1  sticky fetch-timeout error.
REQ-015 state  output  2  encoding IDLE=0, FETCH=1, EXEC=2, HALT=3.

Function
REQ-016 IDLE SHALL last exactly one cycle, then go to FETCH unconditionally.
REQ-017 FETCH SHALL drive fetch_req=1; on fetch_ready=1 it SHALL go to EXEC and pulse instr_valid in the next cycle.
REQ-018 FETCH SHALL count consecutive cycles with fetch_ready=0 using an 8-bit wait counter cleared on entry to FETCH.
REQ-019 On a FETCH cycle with fetch_ready=0 and wait counter == MAX_WAIT-1, it SHALL go to HALT and set fetch_timeout; fetch_ready=1 in that same cycle SHALL win and go to EXEC.
REQ-020 HALT SHALL be left only by reset; pc, fetch_timeout, and all outputs except state SHALL hold, with pulses low.
REQ-021 In EXEC with stall=1, pc SHALL hold and the state SHALL remain EXEC indefinitely; there is no timeout.
REQ-022 In EXEC with stall=0, the state SHALL go to FETCH and pc SHALL load either (branch & zero) ? {branch_target[31:2],2'b00} : pc+4.
REQ-023 branch and zero SHALL be sampled only in the EXEC cycle with stall=0; they SHALL be ignored elsewhere.
REQ-024 flush SHALL pulse in the cycle after a taken-branch pc update, coincident with the new pc.
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 fetch_ready outside FETCH and stall outside EXEC SHALL have no effect.
REQ-027 Update latency SHALL be one cycle: the pc update is visible on the edge that leaves EXEC.

Reset
REQ-028 reset=1 at an edge SHALL set pc=RESET_PC, state=IDLE, fetch_req=0, instr_valid=0, flush=0, fetch_timeout=0, and the wait counter to 0.
REQ-029 Reset SHALL take priority over every state, including mid-FETCH, mid-stall and HALT, with no partial pc update.

Configuration
REQ-030 With BRANCH_COUNT_EN defined, the block SHALL add the port branch_count, output 16, a taken-branch counter.
REQ-031 That counter SHALL reset to 0, increment on each taken update per REQ-022, and saturate at 16'hFFFF.
REQ-032 Without BRANCH_COUNT_EN, the branch_count port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then fetch_ready=1 every cycle and no branches -> pc reads 0, 4, 8, C in successive FETCH entries; instr_valid pulses once per instruction.
REQ-034 With pc=0x10 in EXEC, branch=1, zero=1, branch_target=0x43, stall=0 -> next pc=0x40 and flush=1 for one cycle; with zero=0 the same stimulus gives pc=0x14 and flush=0.
REQ-035 EXEC with stall=1 for 5 cycles, then stall=0 -> pc holds for those 5 cycles, then advances by 4; branch=1, zero=1 during the stall alone has no effect.
REQ-036 fetch_ready held 0 with MAX_WAIT=15 -> after 15 FETCH cycles state=HALT and fetch_timeout=1; then reset -> IDLE with pc=RESET_PC and fetch_timeout=0.
REQ-037 pc=32'hFFFF_FFFC, no branch -> next pc=32'h0000_0000.
REQ-038 With BRANCH_COUNT_EN, 3 taken branches and 2 not taken -> branch_count=3; reset asserted mid-stall -> branch_count=0 and state=IDLE on the next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC sequencer: IDLE/FETCH/EXEC/HALT control with fetch timeout and branch redirect.
// Optional taken-branch counter port enabled by defining BRANCH_COUNT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        fetch_req,
  output logic        instr_valid,
  output logic        flush,
  output logic        fetch_timeout,
`ifdef BRANCH_COUNT_EN
  output logic [15:0] branch_count,
`endif
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  state_t      st, st_n;
  logic [31:0] pc_n;
  logic [7:0]  wait_cnt, wait_n;
  logic        tmo_n, iv_n, flush_n, taken;

  assign state     = st;
  assign fetch_req = (st == FETCH);

  always_comb begin
    st_n    = st;
    pc_n    = pc;
    wait_n  = wait_cnt;
    tmo_n   = fetch_timeout;
    iv_n    = 1'b0;
    flush_n = 1'b0;
    taken   = 1'b0;
    unique case (1'b1)
      (st == IDLE): begin
        st_n   = FETCH;
        wait_n = 8'd0;
      end
      (st == FETCH): begin
        // A ready instruction beats a timeout in the same cycle
        if (fetch_ready) begin
          st_n = EXEC;
          iv_n = 1'b1;
        end else if (wait_cnt == LAST) begin
          st_n  = HALT;
          tmo_n = 1'b1;
        end else begin
          wait_n = wait_cnt + 8'd1;
        end
      end
      (st == EXEC): begin
        if (!stall) begin
          st_n   = FETCH;
          wait_n = 8'd0;
          if (branch && zero) begin
            pc_n    = {branch_target[31:2], 2'b00};
            flush_n = 1'b1;
            taken   = 1'b1;
          end else begin
            pc_n = pc + 32'd4;
          end
        end
      end
      (st == HALT): begin
        st_n = HALT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st            <= IDLE;
      pc            <= RESET_PC;
      wait_cnt      <= 8'd0;
      fetch_timeout <= 1'b0;
      instr_valid   <= 1'b0;
      flush         <= 1'b0;
    end else begin
      st            <= st_n;
      pc            <= pc_n;
      wait_cnt      <= wait_n;
      fetch_timeout <= tmo_n;
      instr_valid   <= iv_n;
      flush         <= flush_n;
    end
  end

`ifdef BRANCH_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset)
      branch_count <= 16'd0;
    else if (taken && branch_count != 16'hFFFF)
      branch_count <= branch_count + 16'd1;
  end
`else
  logic unused_taken;
  assign unused_taken = taken;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Covers fetch/exec flow, branches, stall, wrap, timeout, reset priority.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset, fetch_ready, stall, branch, zero;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        fetch_req, instr_valid, flush, fetch_timeout;
  logic [1:0]  state;
`ifdef BRANCH_COUNT_EN
  logic [15:0] branch_count;
`endif

  int asserts = 0;
  int fails   = 0;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock(clock),
    .reset(reset),
    .fetch_ready(fetch_ready),
    .stall(stall),
    .branch(branch),
    .zero(zero),
    .branch_target(branch_target),
    .pc(pc),
    .fetch_req(fetch_req),
    .instr_valid(instr_valid),
    .flush(flush),
    .fetch_timeout(fetch_timeout),
`ifdef BRANCH_COUNT_EN
    .branch_count(branch_count),
`endif
    .state(state)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] s,
                        input logic [31:0] p, input logic iv,
                        input logic fl);
    chk({tag, " state"}, {30'd0, state}, {30'd0, s});
    chk({tag, " pc"}, pc, p);
    chk({tag, " iv"}, {31'd0, instr_valid}, {31'd0, iv});
    chk({tag, " flush"}, {31'd0, flush}, {31'd0, fl});
  endtask

  initial begin
    reset = 1'b1; fetch_ready = 1'b0; stall = 1'b0;
    branch = 1'b0; zero = 1'b0; branch_target = 32'h0;
    step();
    chk_st("rst", 2'd0, 32'h0, 1'b0, 1'b0);
    chk("rst freq", {31'd0, fetch_req}, 32'd0);
    chk("rst tmo", {31'd0, fetch_timeout}, 32'd0);

    reset = 1'b0; fetch_ready = 1'b1;
    step(); chk_st("f0", 2'd1, 32'h0, 1'b0, 1'b0);
    chk("f0 freq", {31'd0, fetch_req}, 32'd1);
    step(); chk_st("e0", 2'd2, 32'h0, 1'b1, 1'b0);
    chk("e0 freq", {31'd0, fetch_req}, 32'd0);
    step(); chk_st("f4", 2'd1, 32'h4, 1'b0, 1'b0);
    step(); chk_st("e4", 2'd2, 32'h4, 1'b1, 1'b0);
    step(); chk_st("f8", 2'd1, 32'h8, 1'b0, 1'b0);
    step(); chk_st("e8", 2'd2, 32'h8, 1'b1, 1'b0);
    step(); chk_st("fc", 2'd1, 32'hC, 1'b0, 1'b0);
    step(); chk_st("ec", 2'd2, 32'hC, 1'b1, 1'b0);
    step(); chk_st("f10", 2'd1, 32'h10, 1'b0, 1'b0);
    step(); chk_st("e10", 2'd2, 32'h10, 1'b1, 1'b0);

    // taken branch from 0x10, target low bits dropped
    branch = 1'b1; zero = 1'b1; branch_target = 32'h43;
    step(); chk_st("tk", 2'd1, 32'h40, 1'b0, 1'b1);
    step(); chk_st("tk e", 2'd2, 32'h40, 1'b1, 1'b0);
    zero = 1'b0;
    step(); chk_st("ntk", 2'd1, 32'h44, 1'b0, 1'b0);
    step(); chk_st("ntk e", 2'd2, 32'h44, 1'b1, 1'b0);

    // stall with branch inputs active has no effect
    stall = 1'b1; zero = 1'b1; branch_target = 32'h80;
    for (int i = 0; i < 5; i++) begin
      step(); chk_st("stl", 2'd2, 32'h44, 1'b0, 1'b0);
    end
    stall = 1'b0; branch = 1'b0;
    step(); chk_st("stl rel", 2'd1, 32'h48, 1'b0, 1'b0);
    step(); chk_st("e48", 2'd2, 32'h48, 1'b1, 1'b0);

    // wrap through 0xFFFF_FFFC
    branch = 1'b1; zero = 1'b1; branch_target = 32'hFFFF_FFFF;
    step(); chk_st("tfc", 2'd1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    branch = 1'b0;
    step(); chk_st("efc", 2'd2, 32'hFFFF_FFFC, 1'b1, 1'b0);
    step(); chk_st("wrap", 2'd1, 32'h0, 1'b0, 1'b0);
    step(); chk_st("e0b", 2'd2, 32'h0, 1'b1, 1'b0);
    branch = 1'b1; zero = 1'b1; branch_target = 32'h100;
    step(); chk_st("t100", 2'd1, 32'h100, 1'b0, 1'b1);
    step(); chk_st("e100", 2'd2, 32'h100, 1'b1, 1'b0);
    zero = 1'b0;
    step(); chk_st("n104", 2'd1, 32'h104, 1'b0, 1'b0);
`ifdef BRANCH_COUNT_EN
    chk("bcnt3", {16'd0, branch_count}, 32'd3);
`endif
    branch = 1'b0;
    step(); chk_st("e104", 2'd2, 32'h104, 1'b1, 1'b0);

    // reset mid-stall
    stall = 1'b1;
    step(); chk_st("stl2", 2'd2, 32'h104, 1'b0, 1'b0);
    reset = 1'b1;
    step(); chk_st("rst stl", 2'd0, 32'h0, 1'b0, 1'b0);
`ifdef BRANCH_COUNT_EN
    chk("bcnt rst", {16'd0, branch_count}, 32'd0);
`endif
    reset = 1'b0; stall = 1'b0; fetch_ready = 1'b0;

    // ready on the last allowed wait cycle wins over timeout
    step(); chk_st("w1", 2'd1, 32'h0, 1'b0, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      step();
      chk("wb st", {30'd0, state}, 32'd1);
    end
    fetch_ready = 1'b1;
    step(); chk_st("wb win", 2'd2, 32'h0, 1'b1, 1'b0);
    chk("wb tmo", {31'd0, fetch_timeout}, 32'd0);

    // timeout after 15 FETCH cycles
    fetch_ready = 1'b0;
    step(); chk_st("t f4", 2'd1, 32'h4, 1'b0, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      step();
      chk("to st", {30'd0, state}, 32'd1);
      chk("to tmo", {31'd0, fetch_timeout}, 32'd0);
    end
    step(); chk_st("halt", 2'd3, 32'h4, 1'b0, 1'b0);
    chk("halt tmo", {31'd0, fetch_timeout}, 32'd1);
    chk("halt freq", {31'd0, fetch_req}, 32'd0);
    fetch_ready = 1'b1; branch = 1'b1; zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_st("hold", 2'd3, 32'h4, 1'b0, 1'b0);
      chk("hold tmo", {31'd0, fetch_timeout}, 32'd1);
    end
    reset = 1'b1;
    step(); chk_st("rst h", 2'd0, 32'h0, 1'b0, 1'b0);
    chk("rst h tmo", {31'd0, fetch_timeout}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
